// File: rtl/comparator_serial.sv
// Multi-cycle magnitude comparator: walks A/B one DIGIT-bit slice per clock, MSB first.
// Supports unsigned and two's-complement compares, optionally exiting on the first differing slice.
module comparator_serial #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AlB,
  output logic             AgB,
  output logic             AeB
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             done_q, done_d;
  logic             alb_q, alb_d, agb_q, agb_d, aeb_q, aeb_d;
  logic             dec_q, dec_d, dec_lt_q, dec_lt_d, dec_gt_q, dec_gt_d;

  logic [DIGIT-1:0] slice_a, slice_b;
  logic             step_lt, step_gt, fin_lt, fin_gt;

  // Per-step decision; the sign-bit check only applies on the MSB slice.
  always_comb begin
    slice_a = a_q[idx_q*DIGIT +: DIGIT];
    slice_b = b_q[idx_q*DIGIT +: DIGIT];
    step_lt = 1'b0;
    step_gt = 1'b0;
    if (sgn_q && (idx_q == IDX_TOP) && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
      step_lt = a_q[WIDTH-1];
      step_gt = ~a_q[WIDTH-1];
    end else if (slice_a < slice_b) begin
      step_lt = 1'b1;
    end else if (slice_a > slice_b) begin
      step_gt = 1'b1;
    end
    fin_lt = dec_q ? dec_lt_q : step_lt;
    fin_gt = dec_q ? dec_gt_q : step_gt;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    done_d   = 1'b0;
    alb_d    = alb_q;
    agb_d    = agb_q;
    aeb_d    = aeb_q;
    dec_d    = dec_q;
    dec_lt_d = dec_lt_q;
    dec_gt_d = dec_gt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          sgn_d    = signed_mode;
          idx_d    = IDX_TOP;
          dec_d    = 1'b0;
          dec_lt_d = 1'b0;
          dec_gt_d = 1'b0;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (EARLY_EXIT != 0) begin
          if (step_lt || step_gt || (idx_q == '0)) begin
            alb_d   = step_lt;
            agb_d   = step_gt;
            aeb_d   = ~(step_lt | step_gt);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          // Full-latency mode: remember the first decision, keep stepping to slice 0.
          if (!dec_q && (step_lt || step_gt)) begin
            dec_d    = 1'b1;
            dec_lt_d = step_lt;
            dec_gt_d = step_gt;
          end
          if (idx_q == '0) begin
            alb_d   = fin_lt;
            agb_d   = fin_gt;
            aeb_d   = ~(fin_lt | fin_gt);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
      alb_q    <= 1'b0;
      agb_q    <= 1'b0;
      aeb_q    <= 1'b0;
      dec_q    <= 1'b0;
      dec_lt_q <= 1'b0;
      dec_gt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      done_q   <= done_d;
      alb_q    <= alb_d;
      agb_q    <= agb_d;
      aeb_q    <= aeb_d;
      dec_q    <= dec_d;
      dec_lt_q <= dec_lt_d;
      dec_gt_q <= dec_gt_d;
    end
  end

  assign busy = (state_q == COMPARE);
  assign done = done_q;
  assign AlB  = alb_q;
  assign AgB  = agb_q;
  assign AeB  = aeb_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial: an early-exit and a full-latency instance.
// Drivers push expected {result, done cycle}; per-instance monitors pop on every done.
module tb_comparator_serial;

  logic        clk, rst, start0, start1, sm;
  logic [15:0] A, B;
  logic        busy0, done0, alb0, agb0, aeb0;
  logic        busy1, done1, alb1, agb1, aeb1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         dcyc;
    logic [2:0] res;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  comparator_serial #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm), .A(A), .B(B),
    .busy(busy0), .done(done0), .AlB(alb0), .AgB(agb0), .AeB(aeb0)
  );

  comparator_serial #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm), .A(A), .B(B),
    .busy(busy1), .done(done1), .AlB(alb1), .AgB(agb1), .AeB(aeb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("latency0", cyc, e0.dcyc);
        chk("result0", {29'd0, alb0, agb0, aeb0}, {29'd0, e0.res});
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("latency1", cyc, e1.dcyc);
        chk("result1", {29'd0, alb1, agb1, aeb1}, {29'd0, e1.res});
      end
    end
  end

  // Issue one compare, queue its expectation, then count busy cycles until idle.
  task automatic run(input int d, input logic s, input logic [15:0] a, input logic [15:0] b,
                     input int k, input logic [2:0] res);
    int  bc;
    logic bb;
    @(negedge clk);
    A = a; B = b; sm = s;
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    if (d == 0) q0.push_back('{cyc + k, res});
    else        q1.push_back('{cyc + k, res});
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      bb = (d == 0) ? busy0 : busy1;
      if (!bb) break;
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, k);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sm = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy0", {31'd0, busy0}, 32'd0);
    chk("reset_done0", {31'd0, done0}, 32'd0);
    chk("reset_res0", {29'd0, alb0, agb0, aeb0}, 32'd0);
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    chk("reset_res1", {29'd0, alb1, agb1, aeb1}, 32'd0);

    run(0, 1'b0, 16'h0029, 16'h0091, 3, LT);
    run(0, 1'b0, 16'hBEEF, 16'hBEEF, 4, EQ);
    run(0, 1'b1, 16'h8000, 16'h0001, 1, LT);
    run(0, 1'b0, 16'h8000, 16'h0001, 1, GT);
    run(0, 1'b1, 16'hFFFF, 16'hFFFE, 4, GT);
    run(0, 1'b1, 16'h7FFF, 16'h8000, 1, GT);
    run(0, 1'b0, 16'h1000, 16'h0FFF, 1, GT);
    run(1, 1'b0, 16'hA000, 16'h9000, 4, GT);
    run(1, 1'b1, 16'h8000, 16'h0001, 4, LT);
    run(1, 1'b0, 16'h5555, 16'h5555, 4, EQ);

    // Start ignored while busy, then a back-to-back start in the done cycle.
    @(negedge clk);
    A = 16'h1234; B = 16'h1235; sm = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    q0.push_back('{cyc + 4, LT});
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1; A = 16'hFFFF; B = 16'h0000;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_cycle_idle", {31'd0, busy0}, 32'd0);
    start0 = 1'b1; A = 16'h0000; B = 16'h0000;
    @(posedge clk); #1;
    q0.push_back('{cyc + 4, EQ});
    chk("b2b_accepted", {31'd0, busy0}, 32'd1);
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_idle", {31'd0, busy0}, 32'd0);

    // Abort mid-compare with rst: no done, results cleared.
    @(negedge clk);
    A = 16'h1234; B = 16'h1235; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_res", {29'd0, alb0, agb0, aeb0}, 32'd0);
    repeat (5) @(negedge clk);
    run(0, 1'b0, 16'h0010, 16'h0001, 3, GT);

    repeat (3) @(negedge clk);
    chk("pending0", q0.size(), 32'd0);
    chk("pending1", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
